// File: rtl/frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_reader_if
// Description : Job, source-FIFO and downstream pixel-stream signals of the
//               frame reader, bundled with driver (master) and reader (slave)
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_reader_if #(
    parameter int DWIDTH = 24
);
    // job request and geometry
    logic              start;
    logic [10:0]       width;
    logic [10:0]       height;
    logic [10:0]       num_frame;
    // source FIFO (normal, non-show-ahead)
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_q;
    logic              fifo_rdreq;
    // downstream stream
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;
    logic [10:0]       x_cnt;
    logic [10:0]       y_cnt;
    logic [10:0]       frame_cnt;
    // status
    logic              busy;
    logic              done;
    logic              err_cfg;

    modport master (
        output start, width, height, num_frame, fifo_empty, fifo_q, out_ready,
        input  fifo_rdreq, out_data, out_valid, out_sof, out_eol, out_eof,
               x_cnt, y_cnt, frame_cnt, busy, done, err_cfg
    );

    modport slave (
        input  start, width, height, num_frame, fifo_empty, fifo_q, out_ready,
        output fifo_rdreq, out_data, out_valid, out_sof, out_eol, out_eof,
               x_cnt, y_cnt, frame_cnt, busy, done, err_cfg
    );
endinterface
`default_nettype wire

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_reader
// Description : Reads width*height*num_frame pixels from a non-show-ahead
//               FIFO and streams them downstream through a 2-entry skid
//               buffer, tagging each pixel with position and frame markers.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_reader #(
    parameter int DWIDTH = 24
) (
    input  logic          clock,
    input  logic          reset,
    frame_reader_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [10:0]       r_width;
    logic [10:0]       r_height;
    logic [10:0]       r_nframe;
    logic [32:0]       r_rd_rem;
    logic              r_err;
    logic [1:0]        r_occ;
    logic              r_infl;
    logic [DWIDTH-1:0] r_buf0;      // oldest entry, drives out_data
    logic [DWIDTH-1:0] r_buf1;      // skid entry
    logic [10:0]       r_x;
    logic [10:0]       r_y;
    logic [10:0]       r_f;

    logic              w_valid;
    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_rdreq;
    logic              w_eol;
    logic              w_eof;
    logic              w_last_frame;
    logic              w_done;
    logic              w_geom_ok;
    logic              w_accept;
    logic [32:0]       w_total;

    assign w_valid      = (r_occ != 2'd0);
    assign w_pop        = w_valid && bus.out_ready;
    // Entries the buffer will hold once this cycle's pop and pending capture settle.
    assign w_level      = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_rdreq      = (r_state == S_RUN) && !bus.fifo_empty &&
                          (r_rd_rem != 33'd0) && (w_level < 3'd2);
    assign w_eol        = (r_x == r_width - 11'd1);
    assign w_eof        = w_eol && (r_y == r_height - 11'd1);
    assign w_last_frame = (r_f == r_nframe - 11'd1);
    assign w_done       = (r_state == S_DRAIN) && w_pop && w_eof && w_last_frame;
    assign w_geom_ok    = (bus.width != 11'd0) && (bus.height != 11'd0) &&
                          (bus.num_frame != 11'd0);
    assign w_accept     = (r_state == S_IDLE) && bus.start && w_geom_ok;
    assign w_total      = {22'd0, bus.width} * {22'd0, bus.height} * {22'd0, bus.num_frame};

    // Job control: accept or reject start, count outstanding reads, sequence the job.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_width  <= 11'd0;
            r_height <= 11'd0;
            r_nframe <= 11'd0;
            r_rd_rem <= 33'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_geom_ok) begin
                            r_width  <= bus.width;
                            r_height <= bus.height;
                            r_nframe <= bus.num_frame;
                            r_rd_rem <= w_total;
                            r_state  <= S_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rdreq) begin
                        r_rd_rem <= r_rd_rem - 33'd1;
                        if (r_rd_rem == 33'd1) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry output buffer: capture the FIFO word one cycle after each read, pop on transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_occ  <= 2'd0;
            r_infl <= 1'b0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            r_infl <= w_rdreq;
            case ({r_infl, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= bus.fifo_q;
                    end else begin
                        r_buf1 <= bus.fifo_q;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new word lands behind whatever remains
                    if (r_occ == 2'd1) begin
                        r_buf0 <= bus.fifo_q;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= bus.fifo_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Position counters of the pixel at the head of the buffer; advance only on transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x <= 11'd0;
            r_y <= 11'd0;
            r_f <= 11'd0;
        end else if (w_accept) begin
            r_x <= 11'd0;
            r_y <= 11'd0;
            r_f <= 11'd0;
        end else if (w_pop) begin
            if (w_eol) begin
                r_x <= 11'd0;
                if (w_eof) begin
                    r_y <= 11'd0;
                    r_f <= w_last_frame ? 11'd0 : r_f + 11'd1;
                end else begin
                    r_y <= r_y + 11'd1;
                end
            end else begin
                r_x <= r_x + 11'd1;
            end
        end
    end

    assign bus.fifo_rdreq = w_rdreq;
    assign bus.out_data   = r_buf0;
    assign bus.out_valid  = w_valid;
    assign bus.out_sof    = (r_x == 11'd0) && (r_y == 11'd0);
    assign bus.out_eol    = w_eol;
    assign bus.out_eof    = w_eof;
    assign bus.x_cnt      = r_x;
    assign bus.y_cnt      = r_y;
    assign bus.frame_cnt  = r_f;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = w_done;
    assign bus.err_cfg    = r_err;

endmodule
`default_nettype wire

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter DWIDTH, default 24: pixel width in bits, {R,G,B} 8 bits each, R in MSBs.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-005 width, height, num_frame  input  11 each  job geometry; latched on an accepted start.
REQ-006 fifo_empty  input  1  source FIFO empty flag.
REQ-007 fifo_q  input  DWIDTH  source FIFO read data; valid one cycle after fifo_rdreq (normal, non-show-ahead FIFO).
REQ-008 fifo_rdreq  output  1  FIFO pop request.
REQ-009 out_data  output  DWIDTH  pixel to downstream.
REQ-010 out_valid  output  1  out_data and the markers are valid.
REQ-011 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-012 out_sof, out_eol, out_eof  output  1 each  start of frame, end of line, end of frame markers.
REQ-013 x_cnt, y_cnt, frame_cnt  output  11 each  position of the current out_data pixel.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse when the job completes.
REQ-016 err_cfg  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 States: IDLE, RUN, DRAIN; IDLE is the reset state.
REQ-018 IDLE + start with width, height and num_frame all nonzero: latch geometry, load rd_remaining = width*height*num_frame (33-bit, no truncation), clear x/y/frame counters, go to RUN next cycle.
REQ-019 IDLE + start with any geometry field zero: err_cfg high next cycle for one cycle; stay IDLE; nothing latched.
REQ-020 start outside IDLE: ignored; no effect on the latched geometry.
REQ-021 Output buffer: 2 entries (output register plus skid); occ = stored entries, infl = reads issued last cycle (0 or 1).
REQ-022 fifo_rdreq = (state==RUN) && !fifo_empty && rd_remaining!=0 && (occ + infl - pop) < 2, where pop = out_valid && out_ready this cycle; combinational in those terms.
REQ-023 Each fifo_rdreq decrements rd_remaining by 1; fifo_q is captured into the buffer on the following cycle, in FIFO order.
REQ-024 out_valid = (occ != 0); out_data = oldest entry; out_data held stable while out_valid && !out_ready.
REQ-025 Simultaneous capture and pop in one cycle: occ unchanged; order preserved; no data lost or duplicated.
REQ-026 Markers are combinational from the counters: out_sof = (x_cnt==0 && y_cnt==0); out_eol = (x_cnt==width-1); out_eof = out_eol && (y_cnt==height-1).
REQ-027 Counters advance on a transfer only: x_cnt+1; at width-1 x_cnt wraps to 0 and y_cnt+1; at eof y_cnt wraps to 0 and frame_cnt+1.
REQ-028 RUN -> DRAIN on the cycle rd_remaining reaches 0.
REQ-029 DRAIN -> IDLE on the transfer of the eof pixel of frame num_frame-1; done high that cycle (combinational); frame_cnt returns to 0 on that transfer.
REQ-030 width=1: every pixel asserts out_eol. width=1, height=1: every pixel asserts sof, eol and eof.
REQ-031 fifo_empty during RUN: rdreq low; already-buffered data still drains to the output; no bubble is inserted once data is available.
REQ-032 Full throughput: out_ready held high and FIFO never empty gives 1 pixel/cycle after a 2-cycle initial latency from entering RUN.

Reset
REQ-033 Reset asserted at any time, including mid-frame: state=IDLE; occ=infl=0; rd_remaining=0; counters=0; fifo_rdreq, out_valid, busy, done and err_cfg low immediately (asynchronous); in-flight FIFO data is discarded.
REQ-034 After reset release, the next accepted start begins a fresh job with no residue from the aborted job.

Verification
REQ-035 width=4, height=2, num_frame=1, FIFO preloaded with values 1..8, out_ready=1 -> 8 transfers in order 1..8; sof on 1; eol on 4 and 8; eof on 8; done on the cycle pixel 8 transfers.
REQ-036 Same job with out_ready toggling 1/0 every cycle and fifo_empty randomized -> identical data and marker sequence; out_data never changes while stalled; FIFO never popped beyond 8 reads.
REQ-037 start with height=0 -> err_cfg pulses once; busy stays low; fifo_rdreq never asserts.
REQ-038 width=1, height=1, num_frame=3 -> 3 transfers, each with sof=eol=eof=1; frame_cnt 0,1,2; done on the third transfer.
REQ-039 Reset asserted after the 5th transfer of a 4x4 job -> all outputs low within the reset cycle; a following 2x2 job transfers exactly 4 fresh pixels starting at x_cnt=0, y_cnt=0.
REQ-040 start pulsed during RUN with different geometry -> ignored; original job completes unchanged.
